// File: rtl/shift2_seq_pkg.sv
// Shared types and defaults for the shift-by-2 sequencing controller.
package shift2_seq_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_AMT_W = 5;

    localparam logic DIR_LEFT  = 1'b1;
    localparam logic DIR_RIGHT = 1'b0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT2 = 2'd1,
        SHIFT1 = 2'd2,
        DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/shift2_ctl_dec.sv
// Decodes registered FSM state and direction into the shift stage's one-hot
// select lines and their active-low complements.
module shift2_ctl_dec
    import shift2_seq_pkg::*;
(
    input  state_t state,
    input  logic   dir,
    output logic   L_SHIFT,
    output logic   R_SHIFT,
    output logic   NO_SHIFT,
    output logic   LEFT_NOT,
    output logic   RIGHT_NOT,
    output logic   OLD_NOT
);

    // Stage shifts only while iterating; every other state passes through.
    always_comb begin
        L_SHIFT  = 1'b0;
        R_SHIFT  = 1'b0;
        NO_SHIFT = 1'b1;
        if (state == SHIFT2) begin
            L_SHIFT  = (dir == DIR_LEFT);
            R_SHIFT  = (dir == DIR_RIGHT);
            NO_SHIFT = 1'b0;
        end
        LEFT_NOT  = ~L_SHIFT;
        RIGHT_NOT = ~R_SHIFT;
        OLD_NOT   = ~NO_SHIFT;
    end

endmodule

// File: rtl/shift2_seq_ctrl.sv
// Multi-cycle logical shifter: iterates an external shift-by-2 stage and
// finishes odd amounts with one internal 1-bit shift.
module shift2_seq_ctrl
    import shift2_seq_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int AMT_W = DEF_AMT_W
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             REQ_VALID,
    output logic             REQ_READY,
    input  logic [WIDTH-1:0] REQ_DATA,
    input  logic [AMT_W-1:0] REQ_AMT,
    input  logic             REQ_DIR,
    output logic             RSP_VALID,
    input  logic             RSP_READY,
    output logic [WIDTH-1:0] RSP_DATA,
    output logic [WIDTH-1:0] SH_IN,
    input  logic [WIDTH-1:0] SH_OUT,
    output logic             L_SHIFT,
    output logic             R_SHIFT,
    output logic             NO_SHIFT,
    output logic             LEFT_NOT,
    output logic             RIGHT_NOT,
    output logic             OLD_NOT
);

    localparam logic [AMT_W-2:0] CNT_ONE = {{(AMT_W-2){1'b0}}, 1'b1};

    state_t           state, state_d;
    logic [WIDTH-1:0] data, data_d;
    logic [AMT_W-2:0] cnt, cnt_d;
    logic             odd, odd_d;
    logic             dir, dir_d;

    // State and datapath registers; reset drops any in-flight request.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state <= IDLE;
            data  <= '0;
            cnt   <= '0;
            odd   <= 1'b0;
            dir   <= 1'b0;
        end else begin
            state <= state_d;
            data  <= data_d;
            cnt   <= cnt_d;
            odd   <= odd_d;
            dir   <= dir_d;
        end
    end

    // Next-state and datapath update; cnt holds remaining shift-by-2 passes.
    always_comb begin
        state_d = state;
        data_d  = data;
        cnt_d   = cnt;
        odd_d   = odd;
        dir_d   = dir;
        case (state)
            IDLE: begin
                if (REQ_VALID) begin
                    data_d = REQ_DATA;
                    cnt_d  = REQ_AMT[AMT_W-1:1];
                    odd_d  = REQ_AMT[0];
                    dir_d  = REQ_DIR;
                    if (REQ_AMT[AMT_W-1:1] != '0) state_d = SHIFT2;
                    else if (REQ_AMT[0])          state_d = SHIFT1;
                    else                          state_d = DONE;
                end
            end
            SHIFT2: begin
                data_d = SH_OUT;
                cnt_d  = cnt - CNT_ONE;
                if (cnt == CNT_ONE) state_d = odd ? SHIFT1 : DONE;
            end
            SHIFT1: begin
                data_d  = (dir == DIR_LEFT) ? {data[WIDTH-2:0], 1'b0}
                                            : {1'b0, data[WIDTH-1:1]};
                state_d = DONE;
            end
            DONE: begin
                if (RSP_READY) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign REQ_READY = (state == IDLE);
    assign RSP_VALID = (state == DONE);
    assign RSP_DATA  = data;
    assign SH_IN     = data;

    shift2_ctl_dec u_dec (
        .state     (state),
        .dir       (dir),
        .L_SHIFT   (L_SHIFT),
        .R_SHIFT   (R_SHIFT),
        .NO_SHIFT  (NO_SHIFT),
        .LEFT_NOT  (LEFT_NOT),
        .RIGHT_NOT (RIGHT_NOT),
        .OLD_NOT   (OLD_NOT)
    );

endmodule

// File: tb/tb_shift2_seq_ctrl.sv
// Bench for shift2_seq_ctrl with a behavioural shift-by-2 stage on SH_IN/SH_OUT.
module tb_shift2_seq_ctrl;

    logic        CLK = 1'b0;
    logic        RESET_N;
    logic        REQ_VALID;
    logic        REQ_READY;
    logic [31:0] REQ_DATA;
    logic [4:0]  REQ_AMT;
    logic        REQ_DIR;
    logic        RSP_VALID;
    logic        RSP_READY;
    logic [31:0] RSP_DATA;
    logic [31:0] SH_IN;
    logic [31:0] SH_OUT;
    logic        L_SHIFT, R_SHIFT, NO_SHIFT, LEFT_NOT, RIGHT_NOT, OLD_NOT;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_q[$];
    int          lat_q[$];

    // Results of the last do_req call.
    logic [31:0] got;
    int          lat, nl, nr, hold_bad;
    logic        post_rdy, post_vld;

    shift2_seq_ctrl dut (
        .CLK(CLK), .RESET_N(RESET_N),
        .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_DATA(REQ_DATA),
        .REQ_AMT(REQ_AMT), .REQ_DIR(REQ_DIR),
        .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_DATA(RSP_DATA),
        .SH_IN(SH_IN), .SH_OUT(SH_OUT),
        .L_SHIFT(L_SHIFT), .R_SHIFT(R_SHIFT), .NO_SHIFT(NO_SHIFT),
        .LEFT_NOT(LEFT_NOT), .RIGHT_NOT(RIGHT_NOT), .OLD_NOT(OLD_NOT)
    );

    always #5 CLK = ~CLK;

    // Behavioural shift-by-2 stage
    assign SH_OUT = L_SHIFT ? (SH_IN << 2) : R_SHIFT ? (SH_IN >> 2) : SH_IN;

    // Control-line invariants every cycle
    always @(negedge CLK) begin
        checks++;
        if ((int'(L_SHIFT) + int'(R_SHIFT) + int'(NO_SHIFT)) != 1 ||
            LEFT_NOT !== ~L_SHIFT || RIGHT_NOT !== ~R_SHIFT || OLD_NOT !== ~NO_SHIFT) begin
            errors++;
            $display("FAIL ctl_invariant: L=%b R=%b N=%b LN=%b RN=%b ON=%b required one-hot with complements",
                     L_SHIFT, R_SHIFT, NO_SHIFT, LEFT_NOT, RIGHT_NOT, OLD_NOT);
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [31:0] model(input logic [31:0] d, input logic [4:0] a, input logic dr);
        return dr ? (d << a) : (d >> a);
    endfunction

    // Issue one request, wait for the response, hold RSP_READY low for 'hold' cycles.
    task automatic do_req(input logic [31:0] d, input logic [4:0] a, input logic dr, input int hold);
        exp_q.push_back(model(d, a, dr));
        lat_q.push_back(int'(a[4:1]) + int'(a[0]));
        REQ_DATA = d; REQ_AMT = a; REQ_DIR = dr; REQ_VALID = 1'b1;
        step();
        REQ_VALID = 1'b0;
        lat = 0; nl = 0; nr = 0; hold_bad = 0;
        while (!RSP_VALID && lat < 40) begin
            nl += int'(L_SHIFT);
            nr += int'(R_SHIFT);
            step();
            lat++;
        end
        got = RSP_DATA;
        for (int i = 0; i < hold; i++) begin
            step();
            if (RSP_DATA !== got || RSP_VALID !== 1'b1 || REQ_READY !== 1'b0) hold_bad++;
        end
        RSP_READY = 1'b1;
        step();
        RSP_READY = 1'b0;
        post_rdy = REQ_READY;
        post_vld = RSP_VALID;
    endtask

    task automatic check_rsp(input string name);
        logic [31:0] e;
        int          el;
        e  = exp_q.pop_front();
        el = lat_q.pop_front();
        checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL %s_data: got %h expected %h", name, got, e);
        end
        checks++;
        if (lat != el) begin
            errors++;
            $display("FAIL %s_latency: got %0d expected %0d", name, lat, el);
        end
        checks++;
        if (post_rdy !== 1'b1 || post_vld !== 1'b0) begin
            errors++;
            $display("FAIL %s_return_idle: REQ_READY=%b RSP_VALID=%b expected 1 0", name, post_rdy, post_vld);
        end
    endtask

    task automatic test_reset();
        RESET_N = 1'b0; REQ_VALID = 1'b1; REQ_DATA = 32'hAAAA_5555;
        REQ_AMT = 5'd0; REQ_DIR = 1'b0; RSP_READY = 1'b0;
        step(); step();
        checks++;
        if (REQ_READY !== 1'b1 || RSP_VALID !== 1'b0 || RSP_DATA !== 32'h0) begin
            errors++;
            $display("FAIL reset_handshake: REQ_READY=%b RSP_VALID=%b RSP_DATA=%h expected 1 0 0",
                     REQ_READY, RSP_VALID, RSP_DATA);
        end
        checks++;
        if ({NO_SHIFT, L_SHIFT, R_SHIFT, LEFT_NOT, RIGHT_NOT, OLD_NOT} !== 6'b100110) begin
            errors++;
            $display("FAIL reset_controls: N L R LN RN ON = %b expected 100110",
                     {NO_SHIFT, L_SHIFT, R_SHIFT, LEFT_NOT, RIGHT_NOT, OLD_NOT});
        end
        REQ_VALID = 1'b0;
        RESET_N = 1'b1;
        step();
        checks++;
        if (REQ_READY !== 1'b1 || RSP_VALID !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: REQ_READY=%b RSP_VALID=%b expected 1 0", REQ_READY, RSP_VALID);
        end
    endtask

    task automatic test_left_odd();
        do_req(32'h0000_0001, 5'd5, 1'b1, 0);
        check_rsp("left5");
        checks++;
        if (nl != 2 || nr != 0) begin
            errors++;
            $display("FAIL left5_stage_cycles: L=%0d R=%0d expected 2 0", nl, nr);
        end
    endtask

    task automatic test_right_max();
        do_req(32'h8000_0000, 5'd31, 1'b0, 0);
        check_rsp("right31");
        checks++;
        if (nl != 0 || nr != 15) begin
            errors++;
            $display("FAIL right31_stage_cycles: L=%0d R=%0d expected 0 15", nl, nr);
        end
    endtask

    task automatic test_zero_amt();
        do_req(32'hDEAD_BEEF, 5'd0, 1'b1, 0);
        check_rsp("amt0");
        checks++;
        if (nl != 0 || nr != 0) begin
            errors++;
            $display("FAIL amt0_stage_cycles: L=%0d R=%0d expected 0 0", nl, nr);
        end
    endtask

    task automatic test_backpressure();
        do_req(32'hFFFF_FFFF, 5'd4, 1'b0, 3);
        check_rsp("hold");
        checks++;
        if (hold_bad != 0) begin
            errors++;
            $display("FAIL hold_stable: %0d unstable cycles expected 0", hold_bad);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] e;
        exp_q.push_back(model(32'h1234_5678, 5'd0, 1'b0));
        REQ_DATA = 32'h1234_5678; REQ_AMT = 5'd0; REQ_DIR = 1'b0; REQ_VALID = 1'b1;
        step();
        // Second request waits with valid high while the first response is pending.
        REQ_DATA = 32'hCAFE_F00D;
        RSP_READY = 1'b1;
        e = exp_q.pop_front();
        checks++;
        if (RSP_VALID !== 1'b1 || REQ_READY !== 1'b0 || RSP_DATA !== e) begin
            errors++;
            $display("FAIL b2b_first: RSP_VALID=%b REQ_READY=%b RSP_DATA=%h expected 1 0 %h",
                     RSP_VALID, REQ_READY, RSP_DATA, e);
        end
        exp_q.push_back(model(32'hCAFE_F00D, 5'd0, 1'b0));
        step();
        checks++;
        if (RSP_VALID !== 1'b0 || REQ_READY !== 1'b1) begin
            errors++;
            $display("FAIL b2b_gap: RSP_VALID=%b REQ_READY=%b expected 0 1", RSP_VALID, REQ_READY);
        end
        step();
        REQ_VALID = 1'b0;
        e = exp_q.pop_front();
        checks++;
        if (RSP_VALID !== 1'b1 || RSP_DATA !== e) begin
            errors++;
            $display("FAIL b2b_second: RSP_VALID=%b RSP_DATA=%h expected 1 %h", RSP_VALID, RSP_DATA, e);
        end
        step();
        RSP_READY = 1'b0;
    endtask

    task automatic test_reset_mid();
        int seen;
        REQ_DATA = 32'h0000_1000; REQ_AMT = 5'd12; REQ_DIR = 1'b1; REQ_VALID = 1'b1;
        step();
        REQ_VALID = 1'b0;
        step();
        checks++;
        if (L_SHIFT !== 1'b1) begin
            errors++;
            $display("FAIL midreset_in_shift2: L_SHIFT=%b expected 1", L_SHIFT);
        end
        RESET_N = 1'b0;
        step();
        RESET_N = 1'b1;
        checks++;
        if (REQ_READY !== 1'b1 || RSP_VALID !== 1'b0 || RSP_DATA !== 32'h0 || NO_SHIFT !== 1'b1) begin
            errors++;
            $display("FAIL midreset_idle: REQ_READY=%b RSP_VALID=%b RSP_DATA=%h NO_SHIFT=%b expected 1 0 0 1",
                     REQ_READY, RSP_VALID, RSP_DATA, NO_SHIFT);
        end
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            seen += int'(RSP_VALID);
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL midreset_no_rsp: %0d response cycles expected 0", seen);
        end
        do_req(32'h0000_0001, 5'd2, 1'b1, 0);
        check_rsp("after_reset");
    endtask

    task automatic test_random();
        logic [31:0] d;
        logic [4:0]  a;
        logic        dr;
        for (int i = 0; i < 6; i++) begin
            d  = $urandom;
            a  = 5'($urandom_range(0, 31));
            dr = 1'($urandom_range(0, 1));
            do_req(d, a, dr, int'($urandom_range(0, 2)));
            check_rsp("random");
        end
    endtask

    initial begin
        test_reset();
        test_left_odd();
        test_right_max();
        test_zero_amt();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_random();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
